// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared FSM encodings and width helpers for the histogram scan controller
package hist_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Cumulative sum of 2^bits bins of hist_bits each cannot exceed hist_bits+bits.
    function automatic int cum_w(input int hist_bits, input int bits);
        return hist_bits + bits;
    endfunction

    function automatic int mean_w(input int hist_bits, input int bits);
        return hist_bits + 2 * bits;
    endfunction

endpackage

// File: rtl/hist_pct_search.sv
// rtl/hist_pct_search.sv - latches the first bin whose cumulative count reaches a threshold
module hist_pct_search #(
    parameter int BITS = 8,
    parameter int CW   = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            beat_valid_i,
    input  logic [BITS-1:0] bin_i,
    input  logic [CW-1:0]   cum_i,
    input  logic [CW-1:0]   thresh_i,
    output logic            found_o,
    output logic [BITS-1:0] bin_o
);

    logic            found_q;
    logic [BITS-1:0] bin_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            found_q <= 1'b0;
            bin_q   <= '0;
        end else if (clear_i) begin
            found_q <= 1'b0;
            bin_q   <= '0;
        end else if (beat_valid_i && !found_q && (cum_i >= thresh_i)) begin
            found_q <= 1'b1;
            bin_q   <= bin_i;
        end
    end

    assign found_o = found_q;
    assign bin_o   = bin_q;

endmodule

// File: rtl/hist_scan_ctrl.sv
// rtl/hist_scan_ctrl.sv - per-frame histogram scan: total, low/high percentile bins
// Optional weighted sum (mean_sum port) enabled by defining HIST_SCAN_MEAN_EN.
module hist_scan_ctrl
    import hist_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int HIST_BITS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_done,
    input  logic [HIST_BITS+BITS-1:0] low_thresh,
    input  logic [HIST_BITS+BITS-1:0] high_thresh,
    output logic                      hist_en,
    output logic [BITS-1:0]           hist_addr,
    input  logic [HIST_BITS-1:0]      hist_data,
    output logic                      busy,
    output logic                      done,
    output logic [HIST_BITS+BITS-1:0] total,
    output logic [BITS-1:0]           low_bin,
    output logic [BITS-1:0]           high_bin
`ifdef HIST_SCAN_MEAN_EN
    ,
    output logic [HIST_BITS+2*BITS-1:0] mean_sum
`endif
);

    localparam int              CW   = cum_w(HIST_BITS, BITS);
    localparam logic [BITS-1:0] LAST = '1;

    logic [1:0]      state_q, state_d;
    logic [BITS-1:0] addr_q, addr_d;
    logic            beat_q;
    logic [BITS-1:0] bin_q;
    logic [CW-1:0]   cum_q, cum_next;
    logic [CW-1:0]   low_thr_q, high_thr_q;
    logic            pending_q;
    logic [CW-1:0]   total_q;
    logic [BITS-1:0] low_q, high_q;
    logic            start;
    logic            low_found, high_found;
    logic [BITS-1:0] low_hit, high_hit;
    logic [BITS-1:0] low_res, high_res;

    assign start    = (state_q == ST_IDLE) && (frame_done || pending_q);
    assign cum_next = cum_q + CW'(hist_data);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                end
            end
            ST_READ: begin
                if (addr_q == LAST) state_d = ST_DRAIN;
                else                addr_d  = addr_q + 1'b1;
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            beat_q     <= 1'b0;
            bin_q      <= '0;
            cum_q      <= '0;
            low_thr_q  <= '0;
            high_thr_q <= '0;
            pending_q  <= 1'b0;
            total_q    <= '0;
            low_q      <= '0;
            high_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            // Read data lags the address by one cycle; delay valid and bin to match.
            beat_q  <= (state_q == ST_READ);
            bin_q   <= addr_q;
            if (start) begin
                cum_q      <= '0;
                low_thr_q  <= low_thresh;
                high_thr_q <= high_thresh;
            end else if (beat_q) begin
                cum_q <= cum_next;
            end
            if (frame_done && (state_q != ST_IDLE)) pending_q <= 1'b1;
            else if (start)                         pending_q <= 1'b0;
            if (state_q == ST_DONE) begin
                total_q <= cum_q;
                low_q   <= low_res;
                high_q  <= high_res;
            end
        end
    end

    hist_pct_search #(.BITS(BITS), .CW(CW)) u_low (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start),
        .beat_valid_i (beat_q),
        .bin_i        (bin_q),
        .cum_i        (cum_next),
        .thresh_i     (low_thr_q),
        .found_o      (low_found),
        .bin_o        (low_hit)
    );

    hist_pct_search #(.BITS(BITS), .CW(CW)) u_high (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start),
        .beat_valid_i (beat_q),
        .bin_i        (bin_q),
        .cum_i        (cum_next),
        .thresh_i     (high_thr_q),
        .found_o      (high_found),
        .bin_o        (high_hit)
    );

    // An unreached threshold reports the last bin.
    assign low_res  = low_found  ? low_hit  : LAST;
    assign high_res = high_found ? high_hit : LAST;

    assign hist_en   = (state_q == ST_READ);
    assign hist_addr = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign total     = done ? cum_q    : total_q;
    assign low_bin   = done ? low_res  : low_q;
    assign high_bin  = done ? high_res : high_q;

`ifdef HIST_SCAN_MEAN_EN
    localparam int MW = mean_w(HIST_BITS, BITS);

    logic [MW-1:0] mean_acc_q, mean_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mean_acc_q <= '0;
            mean_q     <= '0;
        end else begin
            if (start)       mean_acc_q <= '0;
            else if (beat_q) mean_acc_q <= mean_acc_q + MW'(bin_q) * MW'(hist_data);
            if (state_q == ST_DONE) mean_q <= mean_acc_q;
        end
    end

    assign mean_sum = done ? mean_acc_q : mean_q;
`endif

endmodule
